// File: rtl/bus_pkg.sv
// Shared types for the memory-mapper data bus: master indices, request bundle
// and default bus widths.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } mst_e;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wr_data;
    logic [BUS_BE_W-1:0]   wr_en;
    logic                  req;
    logic                  lock;
  } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on contention the master
// that did not win last time is chosen.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  mst_e       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == MST_CPU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// CPU/DMA arbiter in front of the memory-mapper data bus: round-robin grant,
// optional bus lock with forced release, and one-cycle read-data return.
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W          = BUS_ADDR_W,
  parameter int DATA_W          = BUS_DATA_W,
  parameter int MAX_LOCK_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wr_data,
  input  logic [DATA_W/8-1:0] m0_wr_en,
  output logic                m0_gnt,
  output logic [DATA_W-1:0]   m0_rd_data,
  output logic                m0_rd_valid,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wr_data,
  input  logic [DATA_W/8-1:0] m1_wr_en,
  output logic                m1_gnt,
  output logic [DATA_W-1:0]   m1_rd_data,
  output logic                m1_rd_valid,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wr_data,
  output logic [DATA_W/8-1:0] bus_wr_en,
  input  logic [DATA_W-1:0]   bus_rd_data,
  output logic                lock_timeout
);

  localparam int CNT_W = $clog2(MAX_LOCK_CYCLES + 1);

  mst_e             last_gnt;
  mst_e             lock_owner;
  logic             owner_locked;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       rd_pending;

  logic       timeout_now;
  logic       eff_locked;
  mst_e       eff_last;
  logic       owner_lock;
  logic       other_req;
  logic [1:0] req;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;

  // A lock that has starved the other master this long is dropped in the same
  // cycle, and the round-robin pointer is turned so the waiting master wins.
  assign req         = {m1_req, m0_req};
  assign timeout_now = owner_locked && (lock_cnt == CNT_W'(MAX_LOCK_CYCLES));
  assign eff_locked  = owner_locked && !timeout_now;
  assign eff_last    = timeout_now ? lock_owner : last_gnt;
  assign owner_lock  = (lock_owner == MST_DMA) ? m1_lock : m0_lock;
  assign other_req   = (lock_owner == MST_DMA) ? m0_req : m1_req;

  rr_arbiter2 u_rr (
    .req      (req),
    .last_gnt (eff_last),
    .gnt      (rr_gnt)
  );

  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = 2'b00;
    end else if (eff_locked) begin
      gnt = (lock_owner == MST_DMA) ? {m1_req, 1'b0} : {1'b0, m0_req};
    end else begin
      gnt = rr_gnt;
    end
  end

  assign m0_gnt       = gnt[0];
  assign m1_gnt       = gnt[1];
  assign lock_timeout = timeout_now && !reset;
  assign m0_rd_valid  = rd_pending[0] && !reset;
  assign m1_rd_valid  = rd_pending[1] && !reset;
  assign m0_rd_data   = bus_rd_data;
  assign m1_rd_data   = bus_rd_data;

  always_comb begin
    bus_addr    = '0;
    bus_wr_data = '0;
    bus_wr_en   = '0;
    if (gnt[0]) begin
      bus_addr    = m0_addr;
      bus_wr_data = m0_wr_data;
      bus_wr_en   = m0_wr_en;
    end else if (gnt[1]) begin
      bus_addr    = m1_addr;
      bus_wr_data = m1_wr_data;
      bus_wr_en   = m1_wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt     <= MST_DMA;
      lock_owner   <= MST_CPU;
      owner_locked <= 1'b0;
      lock_cnt     <= '0;
      rd_pending   <= 2'b00;
    end else begin
      // Read data comes back one cycle after the address phase.
      rd_pending <= {gnt[1] && (m1_wr_en == '0), gnt[0] && (m0_wr_en == '0)};

      if (gnt[0]) begin
        last_gnt <= MST_CPU;
      end else if (gnt[1]) begin
        last_gnt <= MST_DMA;
      end else if (timeout_now) begin
        last_gnt <= lock_owner;
      end

      if (eff_locked) begin
        if (!owner_lock) begin
          owner_locked <= 1'b0;
          lock_cnt     <= '0;
        end else begin
          lock_cnt <= other_req ? lock_cnt + CNT_W'(1) : '0;
        end
      end else begin
        lock_cnt <= '0;
        if (gnt[0] && m0_lock) begin
          owner_locked <= 1'b1;
          lock_owner   <= MST_CPU;
        end else if (gnt[1] && m1_lock) begin
          owner_locked <= 1'b1;
          lock_owner   <= MST_DMA;
        end else begin
          owner_locked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a short lock timeout.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
  logic [3:0]  m0_wr_en, m1_wr_en;
  logic        m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic [3:0]  bus_wr_en;
  logic        lock_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_LOCK_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_lock      (m0_lock),
    .m0_addr      (m0_addr),
    .m0_wr_data   (m0_wr_data),
    .m0_wr_en     (m0_wr_en),
    .m0_gnt       (m0_gnt),
    .m0_rd_data   (m0_rd_data),
    .m0_rd_valid  (m0_rd_valid),
    .m1_req       (m1_req),
    .m1_lock      (m1_lock),
    .m1_addr      (m1_addr),
    .m1_wr_data   (m1_wr_data),
    .m1_wr_en     (m1_wr_en),
    .m1_gnt       (m1_gnt),
    .m1_rd_data   (m1_rd_data),
    .m1_rd_valid  (m1_rd_valid),
    .bus_addr     (bus_addr),
    .bus_wr_data  (bus_wr_data),
    .bus_wr_en    (bus_wr_en),
    .bus_rd_data  (bus_rd_data),
    .lock_timeout (lock_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wr_data = 0; m0_wr_en = 0;
    m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wr_data = 0; m1_wr_en = 0;
  endtask

  initial begin
    logic exp_m1;
    logic prev_m1;
    logic exp_m0;

    reset = 1'b1;
    bus_rd_data = '0;
    clear_inputs();

    // Outputs held quiet during reset even with requests present
    cyc();
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_wr_en = 4'hF;
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_wr_en", bus_wr_en, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rd_valid", {m1_rd_valid, m0_rd_valid}, 0);
    chk("rst_timeout", lock_timeout, 0);

    // Lone CPU read, data returns next cycle
    cyc();
    reset = 0; clear_inputs();
    m0_req = 1; m0_addr = 32'h0000_0010;
    #1;
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_m1_gnt", m1_gnt, 0);
    chk("rd_bus_addr", bus_addr, 32'h10);
    chk("rd_wr_en", bus_wr_en, 0);
    cyc();
    clear_inputs(); bus_rd_data = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_valid", m0_rd_valid, 1);
    chk("rd_m0_data", m0_rd_data, 32'hDEAD_BEEF);
    chk("rd_m1_valid", m1_rd_valid, 0);
    chk("idle_gnt", {m1_gnt, m0_gnt}, 0);
    chk("idle_addr", bus_addr, 0);
    chk("idle_wr_en", bus_wr_en, 0);

    // Lone DMA read
    cyc();
    clear_inputs(); m1_req = 1; m1_addr = 32'h300;
    #1;
    chk("dma_rd_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("dma_rd_addr", bus_addr, 32'h300);

    // Both request continuously: alternate starting with CPU
    prev_m1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      clear_inputs();
      m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
      bus_rd_data = 32'hA000_0000 + 32'(k);
      #1;
      exp_m1 = (k % 2) == 1;
      chk("alt_gnt", {m1_gnt, m0_gnt}, exp_m1 ? 2'b10 : 2'b01);
      chk("alt_addr", bus_addr, exp_m1 ? 32'h200 : 32'h100);
      chk("alt_rd_valid", {m1_rd_valid, m0_rd_valid}, prev_m1 ? 2'b10 : 2'b01);
      chk("alt_rd_data", prev_m1 ? m1_rd_data : m0_rd_data, 32'hA000_0000 + 32'(k));
      prev_m1 = exp_m1;
    end

    // DMA write while CPU idle; last alternating read returns to DMA
    cyc();
    clear_inputs();
    m1_req = 1; m1_addr = 32'hC002_0004; m1_wr_data = 32'h1122_3344; m1_wr_en = 4'hF;
    bus_rd_data = 32'hB0B0_B0B0;
    #1;
    chk("wr_prev_rd_valid", {m1_rd_valid, m0_rd_valid}, 2'b10);
    chk("wr_prev_rd_data", m1_rd_data, 32'hB0B0_B0B0);
    chk("wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("wr_wr_en", bus_wr_en, 4'hF);
    chk("wr_addr", bus_addr, 32'hC002_0004);
    chk("wr_data", bus_wr_data, 32'h1122_3344);
    cyc();
    clear_inputs();
    #1;
    chk("wr_after_wr_en", bus_wr_en, 0);
    chk("wr_no_rd_valid", {m1_rd_valid, m0_rd_valid}, 0);
    chk("wr_after_gnt", {m1_gnt, m0_gnt}, 0);
    chk("wr_after_data", bus_wr_data, 0);

    // CPU takes the lock on contention (DMA was granted last)
    cyc();
    clear_inputs();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h400;
    #1;
    chk("lk_take_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("lk_take_to", lock_timeout, 0);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      m0_req = (j % 2) == 0;
      #1;
      exp_m0 = (j % 2) == 0;
      chk("lk_m1_blocked", m1_gnt, 0);
      chk("lk_m0_gnt", m0_gnt, exp_m0);
      chk("lk_no_to", lock_timeout, 0);
    end
    cyc();
    m0_req = 0;
    #1;
    chk("to_pulse", lock_timeout, 1);
    chk("to_m1_gnt", m1_gnt, 1);
    chk("to_m0_gnt", m0_gnt, 0);
    chk("to_addr", bus_addr, 32'h400);
    chk("to_m0_rd_valid", m0_rd_valid, 1);
    cyc();
    clear_inputs();
    #1;
    chk("to_one_cycle", lock_timeout, 0);
    chk("to_m1_rd_valid", m1_rd_valid, 1);

    // Lock release and a new DMA request in the same cycle
    cyc();
    clear_inputs(); m0_req = 1; m0_lock = 1;
    #1;
    chk("rel_take_gnt", m0_gnt, 1);
    cyc();
    clear_inputs(); m1_req = 1;
    #1;
    chk("rel_same_cycle", m1_gnt, 0);
    cyc();
    #1;
    chk("rel_next_cycle", m1_gnt, 1);

    // Reset right after a granted CPU read
    cyc();
    clear_inputs(); m0_req = 1; m0_addr = 32'h500;
    #1;
    chk("rr_rd_gnt", m0_gnt, 1);
    cyc();
    reset = 1; m0_req = 1; m1_req = 1; m1_wr_en = 4'hF;
    #1;
    chk("rr_rd_valid", m0_rd_valid, 0);
    chk("rr_gnt", {m1_gnt, m0_gnt}, 0);
    chk("rr_wr_en", bus_wr_en, 0);
    cyc();
    reset = 0; clear_inputs();
    m0_req = 1; m0_addr = 32'h600; m1_req = 1; m1_addr = 32'h700;
    #1;
    chk("rr_no_stale_valid", m0_rd_valid, 0);
    chk("rr_first_gnt", {m1_gnt, m0_gnt}, 2'b01);

    // Idle cycles leave the round-robin pointer alone
    cyc();
    clear_inputs();
    #1;
    chk("idle2_gnt", {m1_gnt, m0_gnt}, 0);
    chk("idle2_addr", bus_addr, 0);
    cyc();
    #1;
    cyc();
    m0_req = 1; m0_addr = 32'h800; m1_req = 1; m1_addr = 32'h900;
    #1;
    chk("idle2_rr_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("idle2_rr_addr", bus_addr, 32'h900);

    cyc();
    clear_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
